memory_ctrl: RTL and testbench
==============================

MEMORY_CTRL -- requirements
Module: memory_ctrl

Interface
REQ-001 Parameter AWIDTH, default 5: address width; depth = 2**AWIDTH words.
REQ-002 Parameter DWIDTH, default 8: data width; SHALL be a multiple of 8.
REQ-003 Parameter RD_LAT, default 1: read latency in cycles; legal values are 1 and 2.
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req  input  1  access request.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  AWIDTH  word address.
REQ-009 wdata  input  DWIDTH  write data.
REQ-010 be  input  DWIDTH/8  byte enables for writes; bit i covers wdata[8i+7:8i].
REQ-011 ready  output  1  block accepts a request this cycle.
REQ-012 rdata  output  DWIDTH  read data, registered.
REQ-013 rvalid  output  1  one-cycle pulse; rdata holds a completed read.
REQ-014 busy  output  1  initialisation sweep in progress.

Function
REQ-015 Storage: 2**AWIDTH words of DWIDTH bits, single port, separate data in and data out (no tristate bus).
REQ-016 FSM states: INIT and RUN; rst forces INIT with sweep counter = 0.
REQ-017 INIT: each cycle the block writes 0 to mem[counter] and increments counter; after writing address 2**AWIDTH-1 it moves to RUN.
REQ-018 In INIT: ready = 0 and busy = 1. In RUN: ready = 1 and busy = 0.
REQ-019 Cycle numbering: cycle 0 is the first cycle with rst low. The sweep covers cycles 0 .. 2**AWIDTH-1. ready first reads 1 in cycle 2**AWIDTH.
REQ-020 A request is accepted when req and ready are both high at a posedge; req while ready = 0 is ignored and not queued.
REQ-021 Accepted write: mem[addr] byte i <= wdata byte i for each be[i] = 1; bytes with be[i] = 0 are unchanged; be = 0 leaves the word unchanged.
REQ-022 Accepted write: no rvalid pulse and rdata unchanged.
REQ-023 Accepted read at cycle N: rvalid = 1 and rdata = mem[addr] in cycle N+RD_LAT; rvalid = 0 otherwise.
REQ-024 Reads pipeline at one per cycle; back-to-back reads produce back-to-back rvalid pulses in request order.
REQ-025 rdata holds its last read value until the next read completes.
REQ-026 A read accepted the cycle after a write to the same address returns the new data (write-then-read coherence).
REQ-027 RD_LAT = 2 adds one output register stage after the array read; value and ordering are the same as RD_LAT = 1.
REQ-028 Address wrap: addr is used modulo 2**AWIDTH; there is no out-of-range case.

Reset
REQ-029 rst = 1 sets rdata = 0, rvalid = 0, ready = 0, busy = 1, state = INIT, counter = 0.
REQ-030 rst asserted mid-sweep restarts the sweep from address 0 and re-clears the whole array.
REQ-031 rst asserted in RUN drops all in-flight reads: no rvalid for them after reset.
REQ-032 rst asserted in RUN does not block the sweep; memory content after the sweep is all zeros.

Verification
REQ-033 Init timing: AWIDTH=5, release rst -> busy=1/ready=0 for cycles 0..31; ready=1 and busy=0 at cycle 32; reads of all 32 addresses return 0.
REQ-034 Byte enables: DWIDTH=32; write 0xAABBCCDD be=4'hF to addr 3, then 0x11223344 be=4'h5 -> read of addr 3 returns 0xAA22CC44.
REQ-035 Latency: RD_LAT=1 and RD_LAT=2; reads at cycles N, N+1, N+2 to addrs holding 1, 2, 3 -> rvalid high in cycles N+RD_LAT .. N+RD_LAT+2 with rdata 1, 2, 3; rvalid low otherwise.
REQ-036 Coherence: write 0x5A to addr 7 at cycle N, read addr 7 at cycle N+1 -> rdata=0x5A with rvalid at N+1+RD_LAT.
REQ-037 Ignored request: req=1 we=1 addr=0 wdata=0xFF during INIT -> after INIT completes, addr 0 reads 0x00.
REQ-038 Reset mid-operation: write nonzero data, issue a read, assert rst one cycle later -> no rvalid for that read; sweep restarts; addr reads 0 once ready returns.

Source files
------------

// File: rtl/memory_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_ctrl_if
// Brief    : Request/response bundle between a requester and memory_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface memory_ctrl_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) ();
    logic                  req;
    logic                  we;
    logic [AWIDTH-1:0]     addr;
    logic [DWIDTH-1:0]     wdata;
    logic [DWIDTH/8-1:0]   be;
    logic                  ready;
    logic [DWIDTH-1:0]     rdata;
    logic                  rvalid;
    logic                  busy;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rdata, rvalid, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rdata, rvalid, busy
    );
endinterface
`default_nettype wire

// File: rtl/memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : memory_ctrl
// Brief    : Single-port byte-writable memory with zeroing sweep after reset
//            and a 1- or 2-cycle pipelined read path.
// Revision : 1.0 - initial release
// ============================================================================
module memory_ctrl #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    memory_ctrl_if.slave bus
);
    localparam int                c_NBYTES = DWIDTH / 8;
    localparam int                c_DEPTH  = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] c_LAST   = '1;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AWIDTH-1:0]   r_cnt;
    logic [DWIDTH-1:0]   r_mem [c_DEPTH];
    logic                w_ready;
    logic                w_busy;
    logic                w_acc_wr;
    logic                w_acc_rd;
    logic                r_s1_vld;
    logic [DWIDTH-1:0]   r_s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_INIT: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Reset already forces the sweep; never advertise ready under it.
                if (!rst) begin
                    w_ready = 1'b1;
                    w_busy  = 1'b0;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_acc_wr = bus.req && w_ready && bus.we;
    assign w_acc_rd = bus.req && w_ready && !bus.we;

    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_cnt] <= '0;
        end else if (w_acc_wr) begin
            for (int i = 0; i < c_NBYTES; i++) begin
                if (bus.be[i]) begin
                    r_mem[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // Data register only loads on a read, so it holds the last read value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
        end else begin
            r_s1_vld <= w_acc_rd;
            if (w_acc_rd) begin
                r_s1_data <= r_mem[bus.addr];
            end
        end
    end

    generate
        if (RD_LAT >= 2) begin : g_lat2
            logic              r_s2_vld;
            logic [DWIDTH-1:0] r_s2_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s2_vld  <= 1'b0;
                    r_s2_data <= '0;
                end else begin
                    r_s2_vld <= r_s1_vld;
                    if (r_s1_vld) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign bus.rvalid = r_s2_vld;
            assign bus.rdata  = r_s2_data;
        end else begin : g_lat1
            assign bus.rvalid = r_s1_vld;
            assign bus.rdata  = r_s1_data;
        end
    endgenerate

    assign bus.ready = w_ready;
    assign bus.busy  = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_ctrl
// Brief    : Directed bench driving RD_LAT=1 and RD_LAT=2 instances in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_ctrl_if #(.AWIDTH(5), .DWIDTH(32)) ifa ();
    memory_ctrl_if #(.AWIDTH(5), .DWIDTH(32)) ifb ();

    memory_ctrl #(.AWIDTH(5), .DWIDTH(32), .RD_LAT(1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    memory_ctrl #(.AWIDTH(5), .DWIDTH(32), .RD_LAT(2)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic        r_run    = 1'b0;
    logic        r_eva    = 1'b0;
    logic        r_evb    = 1'b0;
    logic        r_pb1_v  = 1'b0;
    logic [31:0] r_pb1_d  = '0;
    logic [31:0] r_last_a = '0;
    logic [31:0] r_last_b = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input logic exp_ready, input logic exp_busy);
        chk("ready_a", {31'b0, ifa.ready}, {31'b0, exp_ready});
        chk("busy_a",  {31'b0, ifa.busy},  {31'b0, exp_busy});
        chk("ready_b", {31'b0, ifb.ready}, {31'b0, exp_ready});
        chk("busy_b",  {31'b0, ifb.busy},  {31'b0, exp_busy});
    endtask

    // One clock cycle: drive both DUTs, advance the expected read pipelines
    // (e = hand-computed data of a read issued this cycle), then check outputs.
    task automatic cyc(input logic rq, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic [31:0] e);
        ifa.req = rq; ifa.we = w; ifa.addr = a; ifa.wdata = d; ifa.be = b;
        ifb.req = rq; ifb.we = w; ifb.addr = a; ifb.wdata = d; ifb.be = b;
        @(posedge clk);
        if (rst) begin
            r_eva = 1'b0; r_evb = 1'b0; r_pb1_v = 1'b0; r_pb1_d = '0;
            r_last_a = '0; r_last_b = '0;
        end else begin
            r_evb = r_pb1_v;
            if (r_pb1_v) r_last_b = r_pb1_d;
            r_eva = rq && !w && r_run;
            if (r_eva) r_last_a = e;
            r_pb1_v = r_eva;
            r_pb1_d = e;
        end
        #1;
        chk("rvalid_a", {31'b0, ifa.rvalid}, {31'b0, r_eva});
        chk("rdata_a",  ifa.rdata, r_last_a);
        chk("rvalid_b", {31'b0, ifb.rvalid}, {31'b0, r_evb});
        chk("rdata_b",  ifb.rdata, r_last_b);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0);
    endtask

    // Sweep while holding a write request that must be ignored.
    task automatic sweep(input logic [31:0] d);
        for (int k = 0; k < 32; k++) begin
            chk_status(1'b0, 1'b1);
            cyc(1'b1, 1'b1, 5'd0, d, 4'hF, 32'h0);
        end
        chk_status(1'b1, 1'b0);
        r_run = 1'b1;
    endtask

    initial begin
        ifa.req = 1'b0; ifa.we = 1'b0; ifa.addr = '0; ifa.wdata = '0; ifa.be = '0;
        ifb.req = 1'b0; ifb.we = 1'b0; ifb.addr = '0; ifb.wdata = '0; ifb.be = '0;

        idle();
        idle();
        chk_status(1'b0, 1'b1);
        rst = 1'b0;
        sweep(32'h0000_00FF);

        // Every address reads zero; address 0 proves the INIT write was dropped.
        for (int k = 0; k < 32; k++) cyc(1'b1, 1'b0, 5'(k), 32'h0, 4'h0, 32'h0);
        idle();
        idle();

        cyc(1'b1, 1'b1, 5'd3, 32'hAABB_CCDD, 4'hF, 32'h0);
        cyc(1'b1, 1'b1, 5'd3, 32'h1122_3344, 4'h5, 32'h0);
        cyc(1'b1, 1'b0, 5'd3, 32'h0, 4'h0, 32'hAA22_CC44);
        cyc(1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 4'h0, 32'h0);
        cyc(1'b1, 1'b0, 5'd3, 32'h0, 4'h0, 32'hAA22_CC44);
        idle();
        idle();

        cyc(1'b1, 1'b1, 5'd10, 32'h1, 4'hF, 32'h0);
        cyc(1'b1, 1'b1, 5'd11, 32'h2, 4'hF, 32'h0);
        cyc(1'b1, 1'b1, 5'd12, 32'h3, 4'hF, 32'h0);
        idle();
        cyc(1'b1, 1'b0, 5'd10, 32'h0, 4'h0, 32'h1);
        cyc(1'b1, 1'b0, 5'd11, 32'h0, 4'h0, 32'h2);
        cyc(1'b1, 1'b0, 5'd12, 32'h0, 4'h0, 32'h3);
        idle();
        idle();
        idle();

        cyc(1'b1, 1'b1, 5'd7, 32'h5A, 4'hF, 32'h0);
        cyc(1'b1, 1'b0, 5'd7, 32'h0, 4'h0, 32'h5A);
        idle();
        idle();

        // Reset one cycle after a read: the RD_LAT=2 pulse must never appear.
        cyc(1'b1, 1'b1, 5'd20, 32'hDEAD_BEEF, 4'hF, 32'h0);
        cyc(1'b1, 1'b0, 5'd20, 32'h0, 4'h0, 32'hDEAD_BEEF);
        rst   = 1'b1;
        r_run = 1'b0;
        idle();
        idle();
        chk_status(1'b0, 1'b1);
        rst = 1'b0;
        sweep(32'h0000_0077);
        cyc(1'b1, 1'b0, 5'd20, 32'h0, 4'h0, 32'h0);
        cyc(1'b1, 1'b0, 5'd7,  32'h0, 4'h0, 32'h0);
        cyc(1'b1, 1'b0, 5'd3,  32'h0, 4'h0, 32'h0);
        cyc(1'b1, 1'b0, 5'd0,  32'h0, 4'h0, 32'h0);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
